// File: rtl/input_interface_ne_if.sv
// Handshake and memory-write bundle between the LLR source, the input loader and the decoder LLR memory.
interface input_interface_ne_if #(
    parameter int ADDRESSWIDTH = 5,
    parameter int NB           = 14,
    parameter int DW           = 32
);
    logic                    load_start;
    logic                    frame_release;
    logic [DW-1:0]           din;
    logic                    din_valid;
    logic                    din_ready;
    logic                    wr_en;
    logic [ADDRESSWIDTH-1:0] LOADADDRESS;
    logic [NB*DW-1:0]        WRDOUT_VEC;
    logic                    load_done;
    logic                    busy;

    modport master (
        output load_start, frame_release, din, din_valid,
        input  din_ready, wr_en, LOADADDRESS, WRDOUT_VEC, load_done, busy
    );

    modport slave (
        input  load_start, frame_release, din, din_valid,
        output din_ready, wr_en, LOADADDRESS, WRDOUT_VEC, load_done, busy
    );
endinterface

// File: rtl/input_interface_ne.sv
// Decoder input loader: packs NB DW-bit words per row and writes LOADCOUNT rows per frame.
// Optional macro INIF_WORD_REVERSE_EN places the first word of a row in the most-significant slot.
module input_interface_ne #(
    parameter int ADDRESSWIDTH = 5,
    parameter int NB           = 14,
    parameter int DW           = 32,
    parameter int LOADCOUNT    = 17
) (
    input logic                 clk,
    input logic                 rst,
    input_interface_ne_if.slave bus
);
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0]           LAST_WORD = CW'(NB - 1);
    localparam logic [ADDRESSWIDTH-1:0] LAST_ROW  = ADDRESSWIDTH'(LOADCOUNT - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE, S_WAIT} state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_wordCnt;
    logic [ADDRESSWIDTH-1:0] r_rowCnt;
    logic [NB*DW-1:0]        r_rowBuf;
    logic                    r_dinReady;
    logic                    r_wrEn;
    logic [ADDRESSWIDTH-1:0] r_loadAddress;
    logic [NB*DW-1:0]        r_wrdoutVec;
    logic                    r_loadDone;
    logic                    r_busy;

    logic                    w_xfer;
    logic [CW-1:0]           w_slot;
    logic [NB*DW-1:0]        w_rowNext;

    // din_ready is only ever high in FILL, so it doubles as the state qualifier.
    assign w_xfer = bus.din_valid && r_dinReady;

`ifdef INIF_WORD_REVERSE_EN
    assign w_slot = LAST_WORD - r_wordCnt;
`else
    assign w_slot = r_wordCnt;
`endif

    always_comb begin
        w_rowNext = r_rowBuf;
        for (int k = 0; k < NB; k++) begin
            if (w_slot == CW'(k)) begin
                w_rowNext[k*DW +: DW] = bus.din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_wordCnt     <= '0;
            r_rowCnt      <= '0;
            r_rowBuf      <= '0;
            r_dinReady    <= 1'b0;
            r_wrEn        <= 1'b0;
            r_loadAddress <= '0;
            r_wrdoutVec   <= '0;
            r_loadDone    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_wrEn     <= 1'b0;
            r_loadDone <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.load_start) begin
                        r_state    <= S_FILL;
                        r_wordCnt  <= '0;
                        r_rowCnt   <= '0;
                        r_dinReady <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (w_xfer) begin
                        r_rowBuf <= w_rowNext;
                        if (r_wordCnt == LAST_WORD) begin
                            r_wordCnt     <= '0;
                            r_wrEn        <= 1'b1;
                            r_wrdoutVec   <= w_rowNext;
                            r_loadAddress <= r_rowCnt;
                            r_rowCnt      <= r_rowCnt + ADDRESSWIDTH'(1);
                            // Ready falls together with the last write so no word of the next frame slips in.
                            if (r_rowCnt == LAST_ROW) begin
                                r_state    <= S_DONE;
                                r_dinReady <= 1'b0;
                            end
                        end else begin
                            r_wordCnt <= r_wordCnt + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_loadDone <= 1'b1;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.frame_release) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.din_ready   = r_dinReady;
    assign bus.wr_en       = r_wrEn;
    assign bus.LOADADDRESS = r_loadAddress;
    assign bus.WRDOUT_VEC  = r_wrdoutVec;
    assign bus.load_done   = r_loadDone;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_input_interface_ne.sv
// Directed bench for input_interface_ne: a behavioural model pushes expected row writes into a
// scoreboard as words are driven, and a negedge monitor pops and compares them when wr_en appears.
module tb_input_interface_ne;
    localparam int AW        = 5;
    localparam int NB        = 14;
    localparam int DW        = 32;
    localparam int LOADCOUNT = 17;
    localparam int ROWW      = NB * DW;
    localparam int FRAMEW    = NB * LOADCOUNT;

    typedef enum {M_IDLE, M_FILL, M_DONE, M_WAIT} mstate_t;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [ROWW-1:0] data;
        int              cyc;
    } wr_t;

    logic clk;
    logic rst;

    input_interface_ne_if #(.ADDRESSWIDTH(AW), .NB(NB), .DW(DW)) bus ();

    input_interface_ne #(
        .ADDRESSWIDTH(AW),
        .NB(NB),
        .DW(DW),
        .LOADCOUNT(LOADCOUNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int              checks   = 0;
    int              failures = 0;
    int              cyc      = 0;
    bit              monEnable = 1'b0;
    wr_t             wrQ[$];
    wr_t             monEntry;
    bit              monExpWr;
    bit              row0Seen = 1'b0;
    logic [ROWW-1:0] row0Cap;

    mstate_t         mState    = M_IDLE;
    int              wc        = 0;
    int              rc        = 0;
    bit              expReady  = 1'b0;
    bit              expBusy   = 1'b0;
    int              doneCyc   = -1;
    logic [ROWW-1:0] modelRow  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [ROWW-1:0] observed,
                               input logic [ROWW-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int slotOf(input int k);
`ifdef INIF_WORD_REVERSE_EN
        return NB - 1 - k;
`else
        return k;
`endif
    endfunction

    // One clock of stimulus; the model decides acceptance and schedules the resulting writes.
    task automatic applyStimulus(input bit start, input bit rel, input logic [DW-1:0] data,
                                 input bit valid, output bit accepted);
        @(negedge clk);
        bus.load_start    = start;
        bus.frame_release = rel;
        bus.din           = data;
        bus.din_valid     = valid;
        checkOutput("din_ready", ROWW'(bus.din_ready), ROWW'(expReady));
        checkOutput("busy", ROWW'(bus.busy), ROWW'(expBusy));
        accepted = valid && expReady;
        case (mState)
            M_IDLE: begin
                if (start) begin
                    mState   = M_FILL;
                    wc       = 0;
                    rc       = 0;
                    expReady = 1'b1;
                    expBusy  = 1'b1;
                end
            end
            M_FILL: begin
                if (accepted) begin
                    modelRow[slotOf(wc)*DW +: DW] = data;
                    if (wc == NB - 1) begin
                        wrQ.push_back('{addr: AW'(rc), data: modelRow, cyc: cyc + 1});
                        wc = 0;
                        rc++;
                        if (rc == LOADCOUNT) begin
                            mState   = M_DONE;
                            expReady = 1'b0;
                            doneCyc  = cyc + 2;
                        end
                    end else begin
                        wc++;
                    end
                end
            end
            M_DONE: mState = M_WAIT;
            M_WAIT: begin
                if (rel) begin
                    mState  = M_IDLE;
                    expBusy = 1'b0;
                end
            end
            default: mState = M_IDLE;
        endcase
    endtask

    task automatic idleCycles(input int n, input bit valid);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, DW'(32'hBAD0 + i), valid, acc);
    endtask

    task automatic sendFrame(input bit gapped, input int releaseAt, input int wordLimit, input int base);
        bit acc;
        bit v;
        int sent;
        int c;
        sent = 0;
        c    = 0;
        applyStimulus(1'b1, 1'b0, '0, 1'b0, acc);
        while (sent < wordLimit && c < 4 * FRAMEW) begin
            v = gapped ? (c % 2 == 0) : 1'b1;
            applyStimulus(1'b0, c == releaseAt, DW'(base + sent), v, acc);
            if (acc) sent++;
            c++;
        end
    endtask

    task automatic releaseFrame();
        bit acc;
        applyStimulus(1'b0, 1'b1, '0, 1'b0, acc);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, acc);
    endtask

    task automatic resetDut(input int n);
        @(negedge clk);
        rst = 1'b0;
        bus.load_start    = 1'b0;
        bus.frame_release = 1'b0;
        bus.din_valid     = 1'b1;
        wrQ.delete();
        doneCyc  = -1;
        mState   = M_IDLE;
        expReady = 1'b0;
        expBusy  = 1'b0;
        repeat (n - 1) @(negedge clk);
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (monEnable) begin
            monExpWr = (wrQ.size() > 0) && (wrQ[0].cyc <= cyc);
            checkOutput("wr_en", ROWW'(bus.wr_en), ROWW'(monExpWr));
            if (monExpWr) begin
                monEntry = wrQ.pop_front();
                checkOutput("LOADADDRESS", ROWW'(bus.LOADADDRESS), ROWW'(monEntry.addr));
                checkOutput("WRDOUT_VEC", bus.WRDOUT_VEC, monEntry.data);
                if (monEntry.addr == '0 && !row0Seen) begin
                    row0Cap  = bus.WRDOUT_VEC;
                    row0Seen = 1'b1;
                end
            end
            checkOutput("load_done", ROWW'(bus.load_done), ROWW'(cyc == doneCyc));
        end
    end

    initial begin
        logic [DW-1:0] expLo;
        logic [DW-1:0] expHi;
        bit            acc;

        rst               = 1'b0;
        bus.load_start    = 1'b0;
        bus.frame_release = 1'b0;
        bus.din           = '0;
        bus.din_valid     = 1'b1;
        repeat (3) @(negedge clk);
        rst       = 1'b1;
        monEnable = 1'b1;
        checkOutput("reset_din_ready", ROWW'(bus.din_ready), '0);
        checkOutput("reset_wr_en", ROWW'(bus.wr_en), '0);
        checkOutput("reset_busy", ROWW'(bus.busy), '0);
        checkOutput("reset_load_done", ROWW'(bus.load_done), '0);
        checkOutput("reset_LOADADDRESS", ROWW'(bus.LOADADDRESS), '0);
        checkOutput("reset_WRDOUT_VEC", bus.WRDOUT_VEC, '0);
        idleCycles(3, 1'b1);

        $display("[TB] frame 1: continuous data");
        sendFrame(1'b0, -1, FRAMEW, 0);
        idleCycles(4, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, acc);
        idleCycles(2, 1'b1);
        checkOutput("pending_writes_f1", ROWW'(wrQ.size()), '0);
        checkOutput("row0_seen", ROWW'(row0Seen), ROWW'(1));
`ifdef INIF_WORD_REVERSE_EN
        expLo = DW'(13);
        expHi = DW'(0);
`else
        expLo = DW'(0);
        expHi = DW'(13);
`endif
        checkOutput("row0_lsb_slot", ROWW'(row0Cap[DW-1:0]), ROWW'(expLo));
        checkOutput("row0_msb_slot", ROWW'(row0Cap[ROWW-1 -: DW]), ROWW'(expHi));
        releaseFrame();

        $display("[TB] frame 2: gapped data with early release");
        sendFrame(1'b1, 50, FRAMEW, 0);
        idleCycles(4, 1'b0);
        checkOutput("pending_writes_f2", ROWW'(wrQ.size()), '0);
        releaseFrame();

        $display("[TB] frame 3: reset after 20 words");
        sendFrame(1'b0, -1, 20, 1000);
        resetDut(2);
        checkOutput("midreset_LOADADDRESS", ROWW'(bus.LOADADDRESS), '0);
        checkOutput("midreset_WRDOUT_VEC", bus.WRDOUT_VEC, '0);
        idleCycles(NB + 4, 1'b1);

        $display("[TB] frame 4: restart after reset");
        sendFrame(1'b0, -1, FRAMEW, 0);
        idleCycles(4, 1'b1);
        checkOutput("pending_writes_f4", ROWW'(wrQ.size()), '0);
        releaseFrame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
